// File: rtl/dispatch_queue.sv
// Dispatch queue: buffers decoded instructions, resolves operands and issues one per cycle to ROB and RS/LSB.
// Optional CDB forwarding at issue is enabled by defining DISPATCH_BYPASS_EN.
module dispatch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ROB_W = 5,
  parameter int unsigned NCDB  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  wrong_commit,
  input  logic                  in_valid,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_imm,
  input  logic [6:0]            in_op,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic                  in_is_ls,
  input  logic                  in_is_jump,
  input  logic                  in_jump_choice,
  output logic                  in_stall,
  input  logic                  rob_full,
  input  logic                  rs_full,
  input  logic                  lsb_full,
  input  logic [ROB_W-1:0]      rob_tail,
  output logic [4:0]            rf_rs1,
  output logic [4:0]            rf_rs2,
  input  logic [ROB_W-1:0]      rf_Qi,
  input  logic [ROB_W-1:0]      rf_Qj,
  input  logic [31:0]           rf_Vi,
  input  logic [31:0]           rf_Vj,
  output logic [ROB_W-1:0]      Qi_check,
  output logic [ROB_W-1:0]      Qj_check,
  input  logic                  Qi_valid,
  input  logic                  Qj_valid,
  input  logic [31:0]           Vi_value,
  input  logic [31:0]           Vj_value,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*ROB_W-1:0] cdb_rob_id,
  input  logic [NCDB*32-1:0]    cdb_res,
  output logic                  to_rob_valid,
  output logic                  to_rs_valid,
  output logic                  to_lsb_valid,
  output logic                  to_rf_valid,
  output logic [31:0]           iss_pc,
  output logic [31:0]           iss_imm,
  output logic [6:0]            iss_op,
  output logic [4:0]            iss_rd,
  output logic [ROB_W-1:0]      iss_rename,
  output logic [ROB_W-1:0]      iss_Qi,
  output logic [ROB_W-1:0]      iss_Qj,
  output logic [31:0]           iss_Vi,
  output logic [31:0]           iss_Vj,
  output logic                  iss_is_jump,
  output logic                  iss_jump_choice
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_ls;
    logic        is_jump;
    logic        jump_choice;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;
  logic            r_to_rob_valid, r_to_rs_valid, r_to_lsb_valid, r_to_rf_valid;
  logic [31:0]     r_iss_pc, r_iss_imm, r_iss_Vi, r_iss_Vj;
  logic [6:0]      r_iss_op;
  logic [4:0]      r_iss_rd;
  logic [ROB_W-1:0] r_iss_rename, r_iss_Qi, r_iss_Qj;
  logic            r_iss_is_jump, r_iss_jump_choice;

  entry_t          w_head, w_in;
  logic            w_enq, w_iss;
  logic [ROB_W-1:0] w_qi_pre, w_qj_pre, w_qi, w_qj;
  logic [31:0]     w_vi_pre, w_vj_pre, w_vi, w_vj;

  assign w_head   = r_mem[r_head];
  assign in_stall = (r_count == CW'(DEPTH));
  assign rf_rs1   = w_head.rs1;
  assign rf_rs2   = w_head.rs2;
  assign Qi_check = w_qi_pre;
  assign Qj_check = w_qj_pre;

  assign w_in  = '{pc: in_pc, imm: in_imm, op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                   is_ls: in_is_ls, is_jump: in_is_jump, jump_choice: in_jump_choice};
  assign w_enq = rdy && in_valid && !in_stall;
  // The stall gate follows the head's own target unit.
  assign w_iss = rdy && (r_count != '0) && !rob_full &&
                 !(w_head.is_ls ? lsb_full : rs_full);

  // Operand resolution: in-flight rename, then ROB ready, then optional CDB.
  always_comb begin
    w_qi_pre = rf_Qi;
    w_vi_pre = rf_Vi;
    w_qj_pre = rf_Qj;
    w_vj_pre = rf_Vj;
    if (r_to_rf_valid && (w_head.rs1 != 5'd0) && (w_head.rs1 == r_iss_rd)) begin
      w_qi_pre = r_iss_rename;
      w_vi_pre = '0;
    end
    if (r_to_rf_valid && (w_head.rs2 != 5'd0) && (w_head.rs2 == r_iss_rd)) begin
      w_qj_pre = r_iss_rename;
      w_vj_pre = '0;
    end
    w_qi = w_qi_pre;
    w_vi = w_vi_pre;
    w_qj = w_qj_pre;
    w_vj = w_vj_pre;
    if ((w_qi_pre != '0) && Qi_valid) begin
      w_qi = '0;
      w_vi = Vi_value;
    end
    if ((w_qj_pre != '0) && Qj_valid) begin
      w_qj = '0;
      w_vj = Vj_value;
    end
`ifdef DISPATCH_BYPASS_EN
    begin : cdb_fwd
      logic hit_i, hit_j;
      hit_i = 1'b0;
      hit_j = 1'b0;
      for (int k = 0; k < int'(NCDB); k++) begin
        if (!hit_i && (w_qi != '0) && cdb_valid[k] && (cdb_rob_id[k*ROB_W +: ROB_W] == w_qi)) begin
          hit_i = 1'b1;
          w_vi  = cdb_res[k*32 +: 32];
        end
        if (!hit_j && (w_qj != '0) && cdb_valid[k] && (cdb_rob_id[k*ROB_W +: ROB_W] == w_qj)) begin
          hit_j = 1'b1;
          w_vj  = cdb_res[k*32 +: 32];
        end
      end
      if (hit_i) w_qi = '0;
      if (hit_j) w_qj = '0;
    end
`endif
  end

`ifndef DISPATCH_BYPASS_EN
  logic w_unused_cdb;
  assign w_unused_cdb = ^{cdb_valid, cdb_rob_id, cdb_res};
`endif

  always_ff @(posedge clk) begin
    if (w_enq && !wrong_commit) r_mem[r_tail] <= w_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      r_to_rob_valid    <= 1'b0;
      r_to_rs_valid     <= 1'b0;
      r_to_lsb_valid    <= 1'b0;
      r_to_rf_valid     <= 1'b0;
      r_iss_pc          <= '0;
      r_iss_imm         <= '0;
      r_iss_op          <= '0;
      r_iss_rd          <= '0;
      r_iss_rename      <= '0;
      r_iss_Qi          <= '0;
      r_iss_Qj          <= '0;
      r_iss_Vi          <= '0;
      r_iss_Vj          <= '0;
      r_iss_is_jump     <= 1'b0;
      r_iss_jump_choice <= 1'b0;
    end else if (rdy) begin
      if (wrong_commit) begin
        r_head         <= '0;
        r_tail         <= '0;
        r_count        <= '0;
        r_to_rob_valid <= 1'b0;
        r_to_rs_valid  <= 1'b0;
        r_to_lsb_valid <= 1'b0;
        r_to_rf_valid  <= 1'b0;
      end else begin
        if (w_enq) r_tail <= r_tail + PW'(1);
        if (w_iss) r_head <= r_head + PW'(1);
        r_count        <= r_count + CW'(w_enq) - CW'(w_iss);
        r_to_rob_valid <= w_iss;
        r_to_rf_valid  <= w_iss;
        r_to_rs_valid  <= w_iss && !w_head.is_ls;
        r_to_lsb_valid <= w_iss && w_head.is_ls;
        if (w_iss) begin
          r_iss_pc          <= w_head.pc;
          r_iss_imm         <= w_head.imm;
          r_iss_op          <= w_head.op;
          r_iss_rd          <= w_head.rd;
          r_iss_rename      <= rob_tail;
          r_iss_Qi          <= w_qi;
          r_iss_Qj          <= w_qj;
          r_iss_Vi          <= w_vi;
          r_iss_Vj          <= w_vj;
          r_iss_is_jump     <= w_head.is_jump;
          r_iss_jump_choice <= w_head.jump_choice;
        end
      end
    end
  end

  assign to_rob_valid    = r_to_rob_valid;
  assign to_rs_valid     = r_to_rs_valid;
  assign to_lsb_valid    = r_to_lsb_valid;
  assign to_rf_valid     = r_to_rf_valid;
  assign iss_pc          = r_iss_pc;
  assign iss_imm         = r_iss_imm;
  assign iss_op          = r_iss_op;
  assign iss_rd          = r_iss_rd;
  assign iss_rename      = r_iss_rename;
  assign iss_Qi          = r_iss_Qi;
  assign iss_Qj          = r_iss_Qj;
  assign iss_Vi          = r_iss_Vi;
  assign iss_Vj          = r_iss_Vj;
  assign iss_is_jump     = r_iss_is_jump;
  assign iss_jump_choice = r_iss_jump_choice;

endmodule

// File: tb/tb_dispatch_queue.sv
// Bench for dispatch_queue: queue-level reference model checked every cycle plus directed literal checks.
module tb_dispatch_queue;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ROB_W = 5;
  localparam int unsigned NCDB  = 2;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, wrong_commit = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] in_pc = '0, in_imm = '0;
  logic [6:0] in_op = '0;
  logic [4:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic in_is_ls = 1'b0, in_is_jump = 1'b0, in_jump_choice = 1'b0;
  logic in_stall;
  logic rob_full = 1'b0, rs_full = 1'b0, lsb_full = 1'b0;
  logic [ROB_W-1:0] rob_tail = '0;
  logic [4:0] rf_rs1, rf_rs2;
  logic [ROB_W-1:0] rf_Qi = '0, rf_Qj = '0;
  logic [31:0] rf_Vi = '0, rf_Vj = '0;
  logic [ROB_W-1:0] Qi_check, Qj_check;
  logic Qi_valid = 1'b0, Qj_valid = 1'b0;
  logic [31:0] Vi_value = '0, Vj_value = '0;
  logic [NCDB-1:0] cdb_valid = '0;
  logic [NCDB*ROB_W-1:0] cdb_rob_id = '0;
  logic [NCDB*32-1:0] cdb_res = '0;
  logic to_rob_valid, to_rs_valid, to_lsb_valid, to_rf_valid;
  logic [31:0] iss_pc, iss_imm, iss_Vi, iss_Vj;
  logic [6:0] iss_op;
  logic [4:0] iss_rd;
  logic [ROB_W-1:0] iss_rename, iss_Qi, iss_Qj;
  logic iss_is_jump, iss_jump_choice;

  dispatch_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .NCDB(NCDB)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .wrong_commit(wrong_commit),
    .in_valid(in_valid), .in_pc(in_pc), .in_imm(in_imm), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_is_ls(in_is_ls), .in_is_jump(in_is_jump), .in_jump_choice(in_jump_choice),
    .in_stall(in_stall), .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_tail(rob_tail), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_Qi(rf_Qi), .rf_Qj(rf_Qj), .rf_Vi(rf_Vi), .rf_Vj(rf_Vj),
    .Qi_check(Qi_check), .Qj_check(Qj_check), .Qi_valid(Qi_valid), .Qj_valid(Qj_valid),
    .Vi_value(Vi_value), .Vj_value(Vj_value),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_res(cdb_res),
    .to_rob_valid(to_rob_valid), .to_rs_valid(to_rs_valid), .to_lsb_valid(to_lsb_valid),
    .to_rf_valid(to_rf_valid), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_op(iss_op),
    .iss_rd(iss_rd), .iss_rename(iss_rename), .iss_Qi(iss_Qi), .iss_Qj(iss_Qj),
    .iss_Vi(iss_Vi), .iss_Vj(iss_Vj), .iss_is_jump(iss_is_jump), .iss_jump_choice(iss_jump_choice)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction FIFO plus the expected issue registers.
  typedef struct {
    logic [31:0] pc, imm;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic is_ls, is_jump, jc;
  } ent_t;

  ent_t q[$];
  logic m_rob, m_rs, m_lsb, m_rf;
  logic [31:0] m_pc, m_imm, m_vi, m_vj;
  logic [6:0] m_op;
  logic [4:0] m_rd;
  logic [ROB_W-1:0] m_ren, m_qi, m_qj;
  logic m_jmp, m_jc;

  task automatic resolve(input logic [4:0] r, input logic [ROB_W-1:0] rfq, input logic [31:0] rfv,
                         input logic qv, input logic [31:0] vv,
                         output logic [ROB_W-1:0] tag, output logic [31:0] val);
    if (m_rf && r != 5'd0 && r == m_rd) begin
      tag = m_ren; val = 32'd0;
    end else begin
      tag = rfq; val = rfv;
    end
    if (tag != '0 && qv) begin
      tag = '0; val = vv;
    end
`ifdef DISPATCH_BYPASS_EN
    if (tag != '0) begin
      for (int k = 0; k < int'(NCDB); k++) begin
        if (tag != '0 && cdb_valid[k] && cdb_rob_id[k*ROB_W +: ROB_W] == tag) begin
          tag = '0; val = cdb_res[k*32 +: 32];
        end
      end
    end
`endif
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      {m_rob, m_rs, m_lsb, m_rf, m_jmp, m_jc} = '0;
      {m_pc, m_imm, m_vi, m_vj, m_op, m_rd, m_ren, m_qi, m_qj} = '0;
    end else if (rdy) begin
      if (wrong_commit) begin
        q.delete();
        {m_rob, m_rs, m_lsb, m_rf} = '0;
      end else begin
        logic can_enq, can_iss;
        logic [ROB_W-1:0] ti, tj;
        logic [31:0] vi, vj;
        can_enq = in_valid && (q.size() < int'(DEPTH));
        can_iss = (q.size() > 0) && !rob_full && !(q[0].is_ls ? lsb_full : rs_full);
        if (can_iss) begin
          resolve(q[0].rs1, rf_Qi, rf_Vi, Qi_valid, Vi_value, ti, vi);
          resolve(q[0].rs2, rf_Qj, rf_Vj, Qj_valid, Vj_value, tj, vj);
          m_pc = q[0].pc; m_imm = q[0].imm; m_op = q[0].op; m_rd = q[0].rd;
          m_ren = rob_tail; m_qi = ti; m_qj = tj; m_vi = vi; m_vj = vj;
          m_jmp = q[0].is_jump; m_jc = q[0].jc;
          m_rs = !q[0].is_ls; m_lsb = q[0].is_ls;
          void'(q.pop_front());
        end else begin
          m_rs = 1'b0; m_lsb = 1'b0;
        end
        m_rob = can_iss; m_rf = can_iss;
        if (can_enq)
          q.push_back('{pc: in_pc, imm: in_imm, op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                        is_ls: in_is_ls, is_jump: in_is_jump, jc: in_jump_choice});
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    chk("strobes_stall", 64'({to_rob_valid, to_rs_valid, to_lsb_valid, to_rf_valid, in_stall}),
        64'({m_rob, m_rs, m_lsb, m_rf, (q.size() == int'(DEPTH))}));
    if (m_rob) begin
      chk("iss_pc_imm", {iss_pc, iss_imm}, {m_pc, m_imm});
      chk("iss_ctl", 64'({iss_op, iss_rd, iss_rename, iss_is_jump, iss_jump_choice}),
          64'({m_op, m_rd, m_ren, m_jmp, m_jc}));
      chk("iss_tags", 64'({iss_Qi, iss_Qj}), 64'({m_qi, m_qj}));
      chk("iss_vals", {iss_Vi, iss_Vj}, {m_vi, m_vj});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic enq(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic ls);
    in_valid = 1'b1; in_pc = pc; in_imm = pc + 32'h100; in_op = 7'(pc[6:0] ^ 7'h13);
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_is_ls = ls;
    in_is_jump = pc[3]; in_jump_choice = pc[2];
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_rob", 64'(to_rob_valid), 64'd0);
    chk("reset_stall", 64'(in_stall), 64'd0);

    // Fill with ROB full, drop the fifth, then drain in order.
    rob_full = 1'b1;
    for (int i = 0; i < 4; i++) enq(32'(4 * i), 5'(i + 1), 5'd0, 5'd0, 1'b0);
    chk("full_stall", 64'(in_stall), 64'd1);
    enq(32'h100, 5'd7, 5'd0, 5'd0, 1'b0);
    chk("full_stall_hold", 64'(in_stall), 64'd1);
    rob_full = 1'b0; rob_tail = 5'd10;
    tick();
    chk("drain_pc0", 64'(iss_pc), 64'h0);
    chk("drain_stall_off", 64'(in_stall), 64'd0);
    for (int k = 1; k < 4; k++) begin
      rob_tail = 5'(10 + k);
      tick();
      chk("drain_pc", 64'(iss_pc), 64'(4 * k));
    end
    tick();
    chk("dropped_not_issued", 64'(to_rob_valid), 64'd0);

    // Per-target stall: ALU passes while LSB is full, the load waits.
    rob_full = 1'b1;
    enq(32'h20, 5'd0, 5'd0, 5'd0, 1'b0);
    enq(32'h24, 5'd0, 5'd0, 5'd0, 1'b1);
    rob_full = 1'b0; lsb_full = 1'b1;
    tick();
    chk("alu_to_rs", 64'({to_rs_valid, iss_pc}), 64'({1'b1, 32'h20}));
    tick();
    chk("load_blocked", 64'(to_rob_valid), 64'd0);
    tick();
    chk("load_blocked2", 64'(to_rob_valid), 64'd0);
    lsb_full = 1'b0;
    tick();
    chk("load_to_lsb", 64'({to_lsb_valid, to_rs_valid, iss_pc}), 64'({1'b1, 1'b0, 32'h24}));

    // Back-to-back dependent pair.
    rob_full = 1'b1;
    enq(32'h30, 5'd5, 5'd0, 5'd0, 1'b0);
    enq(32'h34, 5'd6, 5'd5, 5'd5, 1'b0);
    rob_full = 1'b0; rob_tail = 5'd3;
    tick();
    chk("dep_first_rename", 64'(iss_rename), 64'd3);
    rob_tail = 5'd4;
    tick();
    chk("dep_second", 64'({iss_rename, iss_Qi, iss_Qj}), 64'({5'd4, 5'd3, 5'd3}));

    // CDB forwarding with both channels matching.
    rob_full = 1'b1;
    enq(32'h38, 5'd0, 5'd9, 5'd0, 1'b0);
    rob_full = 1'b0; rf_Qi = 5'd7; rf_Vi = 32'h55;
    cdb_valid = 2'b11; cdb_rob_id = {5'd7, 5'd7}; cdb_res = {32'h22, 32'h11};
    #1;
    chk("qi_check", 64'(Qi_check), 64'd7);
    tick();
`ifdef DISPATCH_BYPASS_EN
    chk("bypass", 64'({iss_Qi, iss_Vi}), 64'({5'd0, 32'h11}));
`else
    chk("no_bypass", 64'({iss_Qi, iss_Vi}), 64'({5'd7, 32'h55}));
`endif
    rf_Qi = '0; rf_Vi = '0; cdb_valid = '0; cdb_rob_id = '0; cdb_res = '0;

    // Flush with enqueue and issue conditions true.
    rob_full = 1'b1;
    enq(32'h40, 5'd1, 5'd0, 5'd0, 1'b0);
    enq(32'h44, 5'd2, 5'd0, 5'd0, 1'b0);
    rob_full = 1'b0; wrong_commit = 1'b1;
    in_valid = 1'b1; in_pc = 32'h48;
    tick();
    in_valid = 1'b0; wrong_commit = 1'b0;
    chk("flush_strobes", 64'({to_rob_valid, to_rs_valid, to_lsb_valid, to_rf_valid, in_stall}), 64'd0);
    tick();
    chk("flush_no_issue", 64'(to_rob_valid), 64'd0);
    tick();

    // rdy low holds the strobes.
    enq(32'h60, 5'd3, 5'd0, 5'd0, 1'b0);
    tick();
    chk("two_edge_issue", 64'({to_rob_valid, iss_pc}), 64'({1'b1, 32'h60}));
    rdy = 1'b0;
    tick();
    chk("rdy_hold", 64'(to_rob_valid), 64'd1);
    rdy = 1'b1;
    tick();
    chk("strobe_one_cycle", 64'(to_rob_valid), 64'd0);

    // Asynchronous reset mid-stream.
    rob_full = 1'b1;
    for (int i = 0; i < 4; i++) enq(32'(32'h70 + 4 * i), 5'd4, 5'd0, 5'd0, 1'b0);
    rob_full = 1'b0;
    tick();
    chk("pre_reset_strobe", 64'(to_rob_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 64'({to_rob_valid, to_rs_valid, to_lsb_valid, to_rf_valid, in_stall}), 64'd0);
    chk("async_reset_pc", 64'(iss_pc), 64'd0);
    #1 rst_n = 1'b1;
    enq(32'h80, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    chk("post_reset_issue", 64'({to_rob_valid, iss_pc}), 64'({1'b1, 32'h80}));
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

Parametrised successor to the single-slot dispatcher: buffers up to DEPTH decoded instructions from the fetch/decode front end and issues at most one per cycle. Each issued instruction goes to the ROB and to exactly one of the RS or LSB. At issue, source operands are resolved from the register file, the ROB ready check, the instruction issued in the previous cycle, and NCDB result broadcast channels. A full RS or LSB stalls only instructions bound for that unit; fetch is stalled only when the queue itself is full.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- ROB_W, 5, ROB id width; id 0 means "no dependency"
- NCDB, 2, number of result broadcast channels; channel 0 has highest priority

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rdy  in  1  global enable; low means all state and outputs hold
- wrong_commit  in  1  synchronous flush
- in_valid  in  1  decoded instruction present
- in_pc  in  32  instruction pc
- in_imm  in  32  immediate
- in_op  in  7  opcode/op class
- in_rd, in_rs1, in_rs2  in  5 each  architectural registers
- in_is_ls, in_is_jump, in_jump_choice  in  1 each  route to LSB / branch / predicted taken
- in_stall  out  1  queue full; an in_valid presented while this is high is dropped
- rob_full, rs_full, lsb_full  in  1 each  back-pressure
- rob_tail  in  ROB_W  rename id for the next issue
- rf_rs1, rf_rs2  out  5  combinational; equal to the head entry's rs1/rs2
- rf_Qi, rf_Qj  in  ROB_W  rename tags from RF
- rf_Vi, rf_Vj  in  32  values from RF
- Qi_check, Qj_check  out  ROB_W  tags sent to the ROB ready lookup
- Qi_valid, Qj_valid  in  1  ROB reports tag ready
- Vi_value, Vj_value  in  32  ROB values
- cdb_valid  in  NCDB  broadcast strobes
- cdb_rob_id  in  NCDB*ROB_W  packed ids; channel k at [k*ROB_W +: ROB_W]
- cdb_res  in  NCDB*32  packed results
- to_rob_valid, to_rs_valid, to_lsb_valid, to_rf_valid  out  1  one-cycle issue strobes
- iss_pc, iss_imm  out  32  issued payload
- iss_op  out  7
- iss_rd  out  5  architectural rd
- iss_rename  out  ROB_W  assigned ROB id
- iss_Qi, iss_Qj  out  ROB_W  resolved tags
- iss_Vi, iss_Vj  out  32  resolved values
- iss_is_jump, iss_jump_choice  out  1

## Operation
- Circular buffer with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Enqueue when rdy && in_valid && !in_stall. in_stall = (count == DEPTH), taken from the registered count.
- Issue when rdy && count≠0 && !rob_full && !(head.is_ls ? lsb_full : rs_full). Because the gate depends on the head's own target, an ALU op at the head still issues while lsb_full is high.
- On issue:
  - to_rob_valid and to_rf_valid are set, plus to_lsb_valid if is_ls, otherwise to_rs_valid.
  - iss_rename = rob_tail.
  - The payload registers are loaded.
- Simultaneous enqueue and issue leaves count unchanged.
- Operand resolution for source X (i or j), evaluated in this priority order:
  1. In-flight rename: if to_rf_valid is high, the register is nonzero, and it equals the previous issue's iss_rd, then tag = iss_rename and value = 0. Otherwise tag/value come from rf_QX/rf_VX.
  2. Qi_check/Qj_check carry this intermediate tag.
  3. If tag≠0 and QX_valid, then tag→0 and value = VX_value.
  4. DISPATCH_BYPASS_EN only: if tag≠0 and the lowest-indexed channel k with cdb_valid[k] has a matching id, then tag→0 and value = its cdb_res.
- wrong_commit (when rdy is high) clears count, head and tail and all four strobes on that edge. Any enqueue or issue in the same cycle is discarded. Payload registers are don't-care.
- Reset (rst_n low, any time, asynchronous) forces every output register to 0, and count, head and tail to 0. in_stall is 0 after reset.

## Timing
- Enqueue to earliest issue strobe: 2 edges. The entry is written at edge 1 and becomes head; issue registers at edge 2.
- Strobes last one cycle unless rdy is low, in which case they hold.
- Steady-state throughput is 1 instruction/cycle.
- Back-to-back dependent issues are correct via the in-flight rename path.
- A full queue drains by one entry per issuing cycle. in_stall deasserts the cycle after the first issue.

## Configuration
- DISPATCH_BYPASS_EN defined: step 4 (CDB forwarding) is enabled.
- Undefined: cdb_* inputs are ignored. An operand produced in the issue cycle keeps its nonzero tag and is captured later by the RS/LSB.

## Test plan
- Reset mid-stream: count=3 with strobes high, then pulse rst_n low → all outputs 0 immediately and in_stall=0. The next enqueue issues 2 edges later.
- Fill with no issue (rob_full=1): 4 enqueues → in_stall=1, and a 5th in_valid is dropped. Release rob_full → 4 consecutive issues in FIFO order, with pcs 0x0,0x4,0x8,0xC.
- Per-target stall: lsb_full=1, head is an ALU op → to_rs_valid pulses. The next head is a load → no issue until lsb_full=0.
- Dependent pair: addi x5 then add x6,x5,x5 issued back-to-back with rob_tail 3 then 4 → second issue has iss_Qi=iss_Qj=3 even though rf_Qi=0.
- Bypass: rf_Qi=7, Qi_valid=0, cdb_valid=2'b11 with ids 7/7 and results 0x11/0x22 → iss_Qi=0, iss_Vi=0x11 (channel 0 wins). Without the macro → iss_Qi=7.
- Flush: count=2 and enqueue+issue conditions true with wrong_commit=1 → after the edge count=0, all strobes 0, and no issue on the following edge.
